bp_update_ctrl: RTL and testbench
=================================

# bp_update_ctrl

Branch-resolution controller between the EX stage, the fetch stage and the branch predictor's shared table port. It checks each resolved branch against the prediction carried down the pipe and, on a mismatch, raises a registered flush/redirect sequence. It queues predictor updates in a small FIFO. It arbitrates the single-ported predictor table between fetch lookups and queued updates, with a starvation bound on updates.

## Interface
Parameters:
- DEPTH, 4: update-FIFO entries; power of two, at least 2.
- FLUSH_CYCLES, 2: cycles `flush_o` stays high per mispredict; at least 1.
- STARVE_LIMIT, 8: consecutive lookup-blocked cycles before an update is forced.

Ports (clock and reset first):
- clk  in  1  clock.
- rst_n  in  1  reset; one clock; synchronous, active-low.
- rdy  in  1  global enable; when 0, all state freezes.
- if_req  in  1  fetch wants the predictor port this cycle.
- if_hold_o  out  1  fetch lookup denied this cycle; fetch holds its PC.
- ex_valid  in  1  EX holds a resolved instruction.
- ex_is_branch  in  1  that instruction is a branch or jump.
- ex_pc  in  32  branch PC.
- ex_taken  in  1  actual direction.
- ex_target  in  32  actual taken target.
- ex_pred_taken  in  1  prediction made at fetch.
- ex_pred_target  in  32  predicted target.
- ex_stall_o  out  1  update FIFO full; EX holds its instruction.
- upd_valid_o  out  1  predictor update strobe; feeds the predictor's is_branch input.
- upd_pc_o  out  32  update PC.
- upd_tar_o  out  32  update target.
- upd_taken_o  out  1  update direction.
- flush_o  out  1  kill IF/ID/EX wrong-path work.
- redirect_valid_o  out  1  one-cycle pulse; fetch loads `redirect_pc_o`.
- redirect_pc_o  out  32  correct next PC.
- br_cnt_o  out  32  resolved branches, saturating.
- mis_cnt_o  out  32  mispredicts, saturating.

## Operation
- A branch is accepted when `ex_valid & ex_is_branch & rdy & ~ex_stall_o & state==IDLE`.
- Each accepted branch enqueues {ex_pc, ex_target, ex_taken} and increments `br_cnt_o`.
- Mispredict means `ex_taken != ex_pred_taken`, or both are taken and `ex_target != ex_pred_target`. A mispredict increments `mis_cnt_o` and moves the FSM IDLE -> FLUSH.
- `redirect_pc_o` = `ex_target` if taken, else `ex_pc + 4`. The add is 32-bit and wraps.
- FSM states:
  - IDLE.
  - FLUSH: a down-counter loads FLUSH_CYCLES; exit to IDLE when it reaches 1.
- In FLUSH, all EX inputs are wrong-path and ignored: no enqueue, no counting. The FIFO keeps draining.
- Arbitration, evaluated while the FIFO is non-empty:
  - Without `if_req`, the head entry dequeues.
  - With `if_req`, the lookup wins and the starvation counter increments.
  - When the counter reaches STARVE_LIMIT, the next cycle forces a dequeue: `if_hold_o=1`, then the counter clears.
  - The counter also clears on every dequeue and whenever the FIFO is empty.
- `ex_stall_o` = FIFO full. Enqueue and dequeue in the same cycle are legal at any occupancy, including full with a forced dequeue.
- Counters saturate at 0xFFFFFFFF.
- `rdy=0`: no enqueue, no dequeue, FSM and counters frozen. `upd_valid_o`, `redirect_valid_o` and `if_hold_o` drive 0; `flush_o` holds its value.
- Reset (`rst_n=0` at a clock edge), including mid-flush:
  - FSM to IDLE, FIFO emptied, starvation counter 0.
  - All outputs 0: `flush_o`, `redirect_valid_o`, `redirect_pc_o`, `upd_*`, `if_hold_o`, `ex_stall_o`, `br_cnt_o`, `mis_cnt_o`.
  - Reset overrides `rdy`.

## Timing
- Mispredict accepted at edge N:
  - `redirect_valid_o`=1 and `flush_o`=1 in cycle N+1.
  - `flush_o` stays high through cycle N+FLUSH_CYCLES.
  - EX inputs are honoured again from cycle N+FLUSH_CYCLES+1.
- `upd_*` outputs are combinational from the FIFO head, gated by the arbitration decision. The earliest update for an entry enqueued at edge N is cycle N+1.
- `if_hold_o` is combinational from registered state; there is no path from `if_req` to `if_hold_o`.
- `ex_stall_o` is registered (FIFO count).

## Structure
- Shared defines file: `InstAddrBus`, `ZeroWord`, `True`/`False`; add `BpuFsmBus` and the IDLE/FLUSH encodings there.
- One sub-module: `bp_upd_fifo`, a parameterised synchronous FIFO with push/pop/full/empty/head. The FSM, arbiter and counters stay in the top level.

## Test plan
- Correct prediction: ex_pc=0x100, taken, target 0x140, predicted identically.
  - Required: no flush.
  - Required: `upd_valid_o` next cycle with pc=0x100, tar=0x140, taken=1.
  - Required: br_cnt=1, mis_cnt=0.
- Direction mispredict: ex_pc=0x200, not taken, predicted taken.
  - Required: `redirect_pc_o`=0x204 with a one-cycle `redirect_valid_o`.
  - Required: `flush_o` high exactly 2 cycles, mis_cnt=1.
  - Required: a branch presented during the flush is not counted.
- Starvation: FIFO holds 1 entry, `if_req` held high.
  - Required: 8 blocked cycles, then `if_hold_o`=1 with `upd_valid_o`=1 on the 9th cycle, then the counter is 0.
- Full FIFO: `if_req` high, 4 back-to-back branches.
  - Required: `ex_stall_o`=1 after the 4th.
  - Required: on the forced dequeue, a simultaneous enqueue succeeds and the count stays 4.
- `rdy` drop mid-flush: `flush_o` holds its value and the counter freezes. After `rdy` returns, the remaining flush cycles complete.
- Reset mid-flush with 3 queued entries: next cycle, all outputs are 0 and the FIFO is empty.

Source files
------------

// File: rtl/bp_update_ctrl_pkg.sv
// Shared definitions for the branch-update controller: bus widths, FSM encodings,
// the queued update payload and a saturating increment helper.
package bp_update_ctrl_pkg;

    localparam int unsigned InstAddrBus = 32;
    localparam logic [InstAddrBus-1:0] ZeroWord = '0;
    localparam logic True  = 1'b1;
    localparam logic False = 1'b0;

    localparam int unsigned BpuFsmBus = 1;
    localparam logic [BpuFsmBus-1:0] BpuIdle  = 1'b0;
    localparam logic [BpuFsmBus-1:0] BpuFlush = 1'b1;

    typedef struct packed {
        logic [InstAddrBus-1:0] pc;
        logic [InstAddrBus-1:0] tar;
        logic                   taken;
    } upd_entry_t;

    localparam int unsigned UpdEntryW = $bits(upd_entry_t);

    // Event counters stick at all-ones instead of wrapping.
    function automatic logic [InstAddrBus-1:0] sat_inc(input logic [InstAddrBus-1:0] v);
        return (v == '1) ? v : v + InstAddrBus'(1);
    endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Synchronous FIFO holding pending predictor updates; a push into a full FIFO
// is taken only when a pop happens in the same cycle.
module bp_upd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 65
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop_ok)      count <= count + CW'(1);
            else if (pop_ok && !push_ok) count <= count - CW'(1);
        end
    end

    // Payload storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/bp_update_ctrl.sv
// Branch-resolution controller: mispredict detection with a timed flush/redirect,
// queued predictor updates and lookup/update arbitration of the predictor port.
module bp_update_ctrl
    import bp_update_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rdy,
    input  logic                   if_req,
    output logic                   if_hold_o,
    input  logic                   ex_valid,
    input  logic                   ex_is_branch,
    input  logic [InstAddrBus-1:0] ex_pc,
    input  logic                   ex_taken,
    input  logic [InstAddrBus-1:0] ex_target,
    input  logic                   ex_pred_taken,
    input  logic [InstAddrBus-1:0] ex_pred_target,
    output logic                   ex_stall_o,
    output logic                   upd_valid_o,
    output logic [InstAddrBus-1:0] upd_pc_o,
    output logic [InstAddrBus-1:0] upd_tar_o,
    output logic                   upd_taken_o,
    output logic                   flush_o,
    output logic                   redirect_valid_o,
    output logic [InstAddrBus-1:0] redirect_pc_o,
    output logic [InstAddrBus-1:0] br_cnt_o,
    output logic [InstAddrBus-1:0] mis_cnt_o
);

    localparam int unsigned FW = $clog2(FLUSH_CYCLES + 1);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    logic [BpuFsmBus-1:0]   state_q, state_d;
    logic [FW-1:0]          flush_cnt_q, flush_cnt_d;
    logic [SW-1:0]          starve_q, starve_d;
    logic                   flush_q, flush_d;
    logic                   redir_q, redir_d;
    logic [InstAddrBus-1:0] redir_pc_q, redir_pc_d;
    logic [InstAddrBus-1:0] br_q, br_d;
    logic [InstAddrBus-1:0] mis_q, mis_d;

    upd_entry_t             enq_c;
    upd_entry_t             head_c;
    logic [UpdEntryW-1:0]   head_bits;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   forced_c;
    logic                   deq_c;
    logic                   accept_c;
    logic                   mispredict_c;

    // A forced dequeue is known from registered state alone, so fetch sees no if_req path.
    assign forced_c     = (starve_q == SW'(STARVE_LIMIT));
    assign deq_c        = rdy & ~fifo_empty & (forced_c | ~if_req);
    assign if_hold_o    = rdy & ~fifo_empty & forced_c;
    assign ex_stall_o   = fifo_full & ~forced_c;
    assign accept_c     = ex_valid & ex_is_branch & rdy & ~ex_stall_o & (state_q == BpuIdle);
    assign mispredict_c = (ex_taken != ex_pred_taken) |
                          (ex_taken & ex_pred_taken & (ex_target != ex_pred_target));

    assign enq_c.pc    = ex_pc;
    assign enq_c.tar   = ex_target;
    assign enq_c.taken = ex_taken;
    assign head_c      = upd_entry_t'(head_bits);

    bp_upd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (UpdEntryW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept_c),
        .din   (enq_c),
        .pop   (deq_c),
        .head  (head_bits),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign upd_valid_o      = deq_c;
    assign upd_pc_o         = deq_c ? head_c.pc : ZeroWord;
    assign upd_tar_o        = deq_c ? head_c.tar : ZeroWord;
    assign upd_taken_o      = deq_c & head_c.taken;
    assign flush_o          = flush_q;
    assign redirect_valid_o = redir_q & rdy;
    assign redirect_pc_o    = redir_pc_q;
    assign br_cnt_o         = br_q;
    assign mis_cnt_o        = mis_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= BpuIdle;
            flush_cnt_q <= '0;
            starve_q    <= '0;
            flush_q     <= False;
            redir_q     <= False;
            redir_pc_q  <= ZeroWord;
            br_q        <= ZeroWord;
            mis_q       <= ZeroWord;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            starve_q    <= starve_d;
            flush_q     <= flush_d;
            redir_q     <= redir_d;
            redir_pc_q  <= redir_pc_d;
            br_q        <= br_d;
            mis_q       <= mis_d;
        end
    end

    // Next-state: everything holds while rdy is low.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        starve_d    = starve_q;
        flush_d     = flush_q;
        redir_d     = redir_q;
        redir_pc_d  = redir_pc_q;
        br_d        = br_q;
        mis_d       = mis_q;

        if (rdy) begin
            redir_d = False;
            case (state_q)
                BpuIdle: begin
                    if (accept_c) begin
                        br_d = sat_inc(br_q);
                        if (mispredict_c) begin
                            mis_d       = sat_inc(mis_q);
                            state_d     = BpuFlush;
                            flush_cnt_d = FW'(FLUSH_CYCLES);
                            flush_d     = True;
                            redir_d     = True;
                            redir_pc_d  = ex_taken ? ex_target : ex_pc + InstAddrBus'(4);
                        end
                    end
                end
                BpuFlush: begin
                    if (flush_cnt_q == FW'(1)) begin
                        state_d = BpuIdle;
                        flush_d = False;
                    end else begin
                        flush_cnt_d = flush_cnt_q - FW'(1);
                    end
                end
                default: state_d = BpuIdle;
            endcase

            if (fifo_empty || deq_c) starve_d = '0;
            else                     starve_d = starve_q + SW'(1);
        end
    end

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Randomised and directed self-checking bench for bp_update_ctrl against a
// queue-based reference model of the update/flush/arbitration rules.
module tb_bp_update_ctrl;

    localparam int DEPTH  = 4;
    localparam int FLUSH  = 2;
    localparam int STARVE = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] tar;
        logic        taken;
    } ent_t;

    logic        clk, rst_n, rdy, if_req, if_hold_o;
    logic        ex_valid, ex_is_branch, ex_taken, ex_pred_taken, ex_stall_o;
    logic [31:0] ex_pc, ex_target, ex_pred_target;
    logic        upd_valid_o, upd_taken_o, flush_o, redirect_valid_o;
    logic [31:0] upd_pc_o, upd_tar_o, redirect_pc_o, br_cnt_o, mis_cnt_o;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    ent_t        m_q[$];
    int          m_starve, m_flush_left;
    bit          m_red_v;
    logic [31:0] m_red_pc, m_br, m_mis;

    bp_update_ctrl #(
        .DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH), .STARVE_LIMIT(STARVE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .if_req(if_req), .if_hold_o(if_hold_o),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc),
        .ex_taken(ex_taken), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
        .ex_pred_target(ex_pred_target), .ex_stall_o(ex_stall_o),
        .upd_valid_o(upd_valid_o), .upd_pc_o(upd_pc_o), .upd_tar_o(upd_tar_o),
        .upd_taken_o(upd_taken_o), .flush_o(flush_o), .redirect_valid_o(redirect_valid_o),
        .redirect_pc_o(redirect_pc_o), .br_cnt_o(br_cnt_o), .mis_cnt_o(mis_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_step();
        bit   deq, acc, mp;
        ent_t e;
        if (!rst_n) begin
            m_q.delete();
            m_starve = 0; m_flush_left = 0; m_red_v = 0;
            m_red_pc = '0; m_br = '0; m_mis = '0;
        end else if (rdy) begin
            deq = (m_q.size() != 0) && (m_starve == STARVE || !if_req);
            acc = (m_flush_left == 0) && ex_valid && ex_is_branch &&
                  !(m_q.size() == DEPTH && m_starve != STARVE);
            m_starve = (m_q.size() == 0 || deq) ? 0 : m_starve + 1;
            if (deq) void'(m_q.pop_front());
            m_red_v = 0;
            if (m_flush_left > 0) m_flush_left--;
            if (acc) begin
                e.pc = ex_pc; e.tar = ex_target; e.taken = ex_taken;
                m_q.push_back(e);
                if (m_br != 32'hFFFF_FFFF) m_br++;
                mp = (ex_taken != ex_pred_taken) || (ex_taken && ex_target != ex_pred_target);
                if (mp) begin
                    if (m_mis != 32'hFFFF_FFFF) m_mis++;
                    m_flush_left = FLUSH;
                    m_red_v  = 1;
                    m_red_pc = ex_taken ? ex_target : ex_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_br(input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                          input logic ptk, input logic [31:0] ptg);
        ex_valid = 1'b1; ex_is_branch = 1'b1; ex_pc = pc; ex_taken = tk;
        ex_target = tg; ex_pred_taken = ptk; ex_pred_target = ptg;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; rdy = 1'b1; ex_valid = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [199:0] got;
        rst_n = 1'b0; rdy = 1'b1; if_req = 1'b0; ex_valid = 1'b0; ex_is_branch = 1'b0;
        ex_pc = '0; ex_taken = 1'b0; ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
        tick(); tick();
        rst_n = 1'b1;
        #2;
        got = {if_hold_o, ex_stall_o, upd_valid_o, upd_pc_o, upd_tar_o, upd_taken_o, flush_o,
               redirect_valid_o, redirect_pc_o, br_cnt_o, mis_cnt_o};
        checks++;
        if (got !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h expected=0", got);
        end
    endtask

    task automatic test_correct();
        do_reset();
        if_req = 1'b0;
        set_br(32'h100, 1'b1, 32'h140, 1'b1, 32'h140);
        tick();
        ex_valid = 1'b0;
        #2;
        checks++;
        if ({upd_valid_o, upd_pc_o, upd_tar_o, upd_taken_o} !== {1'b1, 32'h100, 32'h140, 1'b1}) begin
            failures++;
            $display("FAIL correct_update got v=%b pc=%h tar=%h tk=%b expected 1/100/140/1",
                     upd_valid_o, upd_pc_o, upd_tar_o, upd_taken_o);
        end
        checks++;
        if ({flush_o, redirect_valid_o} !== 2'b00) begin
            failures++;
            $display("FAIL correct_noflush got flush=%b redir=%b expected 0/0", flush_o, redirect_valid_o);
        end
        checks++;
        if (br_cnt_o !== 32'd1 || mis_cnt_o !== 32'd0) begin
            failures++;
            $display("FAIL correct_counts got br=%0d mis=%0d expected 1/0", br_cnt_o, mis_cnt_o);
        end
        tick();
    endtask

    task automatic test_mispredict();
        if_req = 1'b0;
        set_br(32'h200, 1'b0, 32'h280, 1'b1, 32'h280);
        tick();
        set_br(32'h500, 1'b1, 32'h540, 1'b1, 32'h540);
        #2;
        checks++;
        if ({redirect_valid_o, flush_o, redirect_pc_o, mis_cnt_o} !== {2'b11, 32'h204, 32'd1}) begin
            failures++;
            $display("FAIL mispred_first got rv=%b fl=%b rpc=%h mis=%0d expected 1/1/204/1",
                     redirect_valid_o, flush_o, redirect_pc_o, mis_cnt_o);
        end
        tick();
        #2;
        checks++;
        if ({redirect_valid_o, flush_o} !== 2'b01) begin
            failures++;
            $display("FAIL mispred_second got rv=%b fl=%b expected 0/1", redirect_valid_o, flush_o);
        end
        tick();
        #2;
        checks++;
        if ({flush_o, br_cnt_o, mis_cnt_o} !== {1'b0, 32'd2, 32'd1}) begin
            failures++;
            $display("FAIL mispred_end got fl=%b br=%0d mis=%0d expected 0/2/1",
                     flush_o, br_cnt_o, mis_cnt_o);
        end
        ex_valid = 1'b0;
        tick(); tick();
    endtask

    task automatic test_starvation();
        do_reset();
        if_req = 1'b1;
        set_br(32'h300, 1'b1, 32'h3c0, 1'b1, 32'h3c0);
        tick();
        ex_valid = 1'b0;
        for (int i = 0; i < STARVE; i++) begin
            #2;
            checks++;
            if ({if_hold_o, upd_valid_o} !== 2'b00) begin
                failures++;
                $display("FAIL starve_blocked cyc=%0d got hold=%b upd=%b expected 0/0", i, if_hold_o, upd_valid_o);
            end
            tick();
        end
        #2;
        checks++;
        if ({if_hold_o, upd_valid_o, upd_pc_o} !== {2'b11, 32'h300}) begin
            failures++;
            $display("FAIL starve_forced got hold=%b upd=%b pc=%h expected 1/1/300", if_hold_o, upd_valid_o, upd_pc_o);
        end
        tick();
        #2;
        checks++;
        if ({if_hold_o, upd_valid_o} !== 2'b00) begin
            failures++;
            $display("FAIL starve_after got hold=%b upd=%b expected 0/0", if_hold_o, upd_valid_o);
        end
    endtask

    task automatic test_full();
        logic [31:0] pcs [5];
        do_reset();
        if_req = 1'b1;
        for (int i = 0; i < 5; i++) pcs[i] = 32'h1000 + 32'(i) * 32'h10;
        for (int i = 0; i < 4; i++) begin
            set_br(pcs[i], 1'b0, 32'h0, 1'b0, 32'h0);
            tick();
        end
        set_br(pcs[4], 1'b0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            #2;
            checks++;
            if ({ex_stall_o, if_hold_o} !== 2'b10) begin
                failures++;
                $display("FAIL full_stall cyc=%0d got stall=%b hold=%b expected 1/0", i, ex_stall_o, if_hold_o);
            end
            tick();
        end
        #2;
        checks++;
        if ({ex_stall_o, if_hold_o, upd_valid_o, upd_pc_o} !== {3'b011, pcs[0]}) begin
            failures++;
            $display("FAIL full_forced got stall=%b hold=%b upd=%b pc=%h expected 0/1/1/%h",
                     ex_stall_o, if_hold_o, upd_valid_o, upd_pc_o, pcs[0]);
        end
        tick();
        ex_valid = 1'b0;
        if_req = 1'b0;
        #2;
        checks++;
        if (ex_stall_o !== 1'b1) begin
            failures++;
            $display("FAIL full_after_swap got stall=%b expected 1", ex_stall_o);
        end
        for (int i = 1; i < 5; i++) begin
            checks++;
            if ({upd_valid_o, upd_pc_o} !== {1'b1, pcs[i]}) begin
                failures++;
                $display("FAIL full_drain idx=%0d got v=%b pc=%h expected 1/%h", i, upd_valid_o, upd_pc_o, pcs[i]);
            end
            tick();
            #2;
        end
        checks++;
        if (upd_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL full_drained got upd=%b expected 0", upd_valid_o);
        end
    endtask

    task automatic test_rdy_flush();
        do_reset();
        if_req = 1'b0;
        set_br(32'h400, 1'b1, 32'h480, 1'b1, 32'h4c0);
        tick();
        ex_valid = 1'b0;
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++;
            if ({flush_o, redirect_valid_o, upd_valid_o, if_hold_o} !== 4'b1000) begin
                failures++;
                $display("FAIL rdy_frozen cyc=%0d got fl=%b rv=%b upd=%b hold=%b expected 1/0/0/0",
                         i, flush_o, redirect_valid_o, upd_valid_o, if_hold_o);
            end
            tick();
        end
        rdy = 1'b1;
        #2;
        checks++;
        if ({flush_o, redirect_pc_o} !== {1'b1, 32'h480}) begin
            failures++;
            $display("FAIL rdy_resume1 got fl=%b rpc=%h expected 1/480", flush_o, redirect_pc_o);
        end
        tick();
        #2;
        checks++;
        if (flush_o !== 1'b1) begin
            failures++;
            $display("FAIL rdy_resume2 got fl=%b expected 1", flush_o);
        end
        tick();
        #2;
        checks++;
        if (flush_o !== 1'b0) begin
            failures++;
            $display("FAIL rdy_resume_end got fl=%b expected 0", flush_o);
        end
    endtask

    task automatic test_reset_flush();
        logic [199:0] got;
        do_reset();
        if_req = 1'b1;
        set_br(32'h10, 1'b1, 32'h50, 1'b1, 32'h50); tick();
        set_br(32'h20, 1'b0, 32'h0, 1'b0, 32'h0);   tick();
        set_br(32'h30, 1'b1, 32'h80, 1'b0, 32'h0);  tick();
        ex_valid = 1'b0;
        rst_n = 1'b0; rdy = 1'b0; if_req = 1'b0;
        tick();
        rst_n = 1'b1; rdy = 1'b1;
        #2;
        got = {if_hold_o, ex_stall_o, upd_valid_o, upd_pc_o, upd_tar_o, upd_taken_o, flush_o,
               redirect_valid_o, redirect_pc_o, br_cnt_o, mis_cnt_o};
        checks++;
        if (got !== '0) begin
            failures++;
            $display("FAIL reset_midflush got=%h expected=0", got);
        end
        tick();
        #2;
        checks++;
        if ({upd_valid_o, flush_o} !== 2'b00) begin
            failures++;
            $display("FAIL reset_empty got upd=%b fl=%b expected 0/0", upd_valid_o, flush_o);
        end
    endtask

    task automatic test_random();
        logic [4:0]  got_ctl, exp_ctl;
        logic [64:0] got_upd, exp_upd;
        bit          edeq;
        for (int c = 0; c < 3000; c++) begin
            rst_n          = ($urandom_range(0, 199) != 0);
            rdy            = ($urandom_range(0, 9) != 0);
            if_req         = ($urandom_range(0, 9) < 8);
            ex_valid       = ($urandom_range(0, 9) < 6);
            ex_is_branch   = ($urandom_range(0, 9) < 8);
            ex_pc          = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 19) == 0) ex_pc = 32'hFFFF_FFFC;
            ex_taken       = 1'($urandom_range(0, 1));
            ex_pred_taken  = ($urandom_range(0, 3) == 0) ? ~ex_taken : ex_taken;
            ex_target      = $urandom() & 32'hFFFF_FFFC;
            ex_pred_target = ($urandom_range(0, 3) == 0) ? (ex_target ^ 32'h40) : ex_target;
            #2;
            edeq    = rdy && (m_q.size() != 0) && (m_starve == STARVE || !if_req);
            exp_ctl = {edeq, rdy && (m_q.size() != 0) && (m_starve == STARVE),
                       (m_q.size() == DEPTH) && (m_starve != STARVE),
                       m_flush_left > 0, rdy && m_red_v};
            got_ctl = {upd_valid_o, if_hold_o, ex_stall_o, flush_o, redirect_valid_o};
            checks++;
            if (got_ctl !== exp_ctl) begin
                failures++;
                $display("FAIL rand_ctl cyc=%0d got(v,hold,stall,fl,rv)=%b expected=%b", c, got_ctl, exp_ctl);
            end
            exp_upd = edeq ? {m_q[0].pc, m_q[0].tar, m_q[0].taken} : '0;
            got_upd = {upd_pc_o, upd_tar_o, upd_taken_o};
            checks++;
            if (got_upd !== exp_upd) begin
                failures++;
                $display("FAIL rand_upd cyc=%0d got=%h expected=%h", c, got_upd, exp_upd);
            end
            checks++;
            if (redirect_pc_o !== m_red_pc) begin
                failures++;
                $display("FAIL rand_rpc cyc=%0d got=%h expected=%h", c, redirect_pc_o, m_red_pc);
            end
            checks++;
            if ({br_cnt_o, mis_cnt_o} !== {m_br, m_mis}) begin
                failures++;
                $display("FAIL rand_cnt cyc=%0d got br=%0d mis=%0d expected br=%0d mis=%0d",
                         c, br_cnt_o, mis_cnt_o, m_br, m_mis);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_correct();
        test_mispredict();
        test_starvation();
        test_full();
        test_rdy_flush();
        test_reset_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
